// File: rtl/msi_spi_slave_rx.sv
// rtl/msi_spi_slave_rx.sv - serial-to-parallel receiver for an external MSI-style SPI initiator
//
// Purpose: samples an asynchronous 3-wire serial link (SCLK, active-low CS,
// MSB-first SDATA) in the clk domain, assembles DATA_W-bit words and queues
// them for a valid/ready consumer. Sticky flags report overflow and frames
// that end mid-word.
//
// Configuration macro: MSI_RX_FIFO_EN
//   defined   -> FIFO_DEPTH-entry receive FIFO
//   undefined -> single holding register (rx_level is 0 or 1), FIFO_DEPTH unused
//
// Ports:
//   clk        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   MSI_SCLK   in   asynchronous serial clock
//   MSI_CS     in   asynchronous chip select, active-low
//   MSI_SDATA  in   asynchronous serial data, MSB first
//   rx_data    out  head-of-queue word
//   rx_valid   out  rx_data is valid
//   rx_ready   in   consumer accepts word when rx_valid & rx_ready
//   rx_level   out  number of words held
//   ovf_err    out  sticky: a word arrived while storage was full
//   frame_err  out  sticky: CS rose with a partial word
//   clr_err    in   one-cycle pulse clearing both sticky flags

module msi_spi_slave_rx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              MSI_SCLK,
    input  logic              MSI_CS,
    input  logic              MSI_SDATA,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [4:0]        rx_level,
    output logic              ovf_err,
    output logic              frame_err,
    input  logic              clr_err
);

    localparam int              CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

    // Elaboration-time guard on the supported parameter ranges.
    if (DATA_W < 8 || DATA_W > 32 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("msi_spi_slave_rx: DATA_W or FIFO_DEPTH out of range");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

    // Synchronizers; CS idles high so its flops reset to 1.
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_cs_s1, r_cs_s2;
    logic r_sdata_s1, r_sdata_s2;

    state_t            r_state;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_ovf_err, r_frame_err;

    logic              w_sclk_rise;
    logic [DATA_W-1:0] w_word;
    logic              w_push, w_pop, w_wr, w_full, w_ovf_evt, w_frame_evt;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sclk_d   <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
        end else begin
            r_sclk_s1  <= MSI_SCLK;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_d   <= r_sclk_s2;
            r_cs_s1    <= MSI_CS;
            r_cs_s2    <= r_cs_s1;
            r_sdata_s1 <= MSI_SDATA;
            r_sdata_s2 <= r_sdata_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    // Word as it will look after this rise's sample is shifted in.
    assign w_word      = {r_shift[DATA_W-2:0], r_sdata_s2};
    // CS deassertion wins over a coincident SCLK rise.
    assign w_push      = (r_state == ST_SHIFT) && !r_cs_s2 && w_sclk_rise &&
                         (r_bit_cnt == LAST_BIT);
    assign w_frame_evt = (r_state == ST_SHIFT) && r_cs_s2 && (r_bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!r_cs_s2) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_cs_s2) begin
                        r_state <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_word;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_ovf_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (clr_err) begin
                r_ovf_err <= 1'b0;
            end
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign ovf_err   = r_ovf_err;
    assign frame_err = r_frame_err;

    // A full store still takes a new word when the head leaves in the same cycle.
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_evt = w_push && w_full && !w_pop;

`ifdef MSI_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [4:0]        r_count;

    assign w_full = (r_count == 5'(FIFO_DEPTH));
    assign w_pop  = rx_ready && (r_count != 5'd0);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {4'd0, w_wr} - {4'd0, w_pop};
        end
    end

    assign rx_data  = r_mem[r_rd_ptr];
    assign rx_valid = (r_count != 5'd0);
    assign rx_level = r_count;
`else
    logic [DATA_W-1:0] r_hold;
    logic              r_full;

    assign w_full = r_full;
    assign w_pop  = rx_ready && r_full;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_wr) begin
            r_hold <= w_word;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end

    assign rx_data  = r_hold;
    assign rx_valid = r_full;
    assign rx_level = {4'd0, r_full};
`endif

endmodule

// File: tb/tb_msi_spi_slave_rx.sv
// tb/tb_msi_spi_slave_rx.sv - directed scoreboard bench for msi_spi_slave_rx

module tb_msi_spi_slave_rx;

`ifdef MSI_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        RST, MSI_SCLK, MSI_CS, MSI_SDATA, rx_ready, clr_err;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [4:0]  rx_level;
    logic        ovf_err, frame_err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] q[$];
    logic        exp_ovf   = 1'b0;
    logic        exp_frame = 1'b0;

    always #5 clk = ~clk;

    msi_spi_slave_rx #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .RST       (RST),
        .MSI_SCLK  (MSI_SCLK),
        .MSI_CS    (MSI_CS),
        .MSI_SDATA (MSI_SDATA),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .ovf_err   (ovf_err),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_begin();
        MSI_SCLK = 1'b0;
        MSI_CS   = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        MSI_SCLK = 1'b0;
        MSI_CS   = 1'b1;
        wait_clk(4);
    endtask

    // mode 0: plain; 1: rx_ready high in the push cycle; 2: clr_err high in the push cycle
    task automatic send_word(input logic [15:0] w, input int mode);
        for (int i = 15; i >= 0; i--) begin
            MSI_SDATA = w[i];
            MSI_SCLK  = 1'b0;
            wait_clk(4);
            MSI_SCLK  = 1'b1;
            if (i == 0 && mode != 0) begin
                // Rise is synchronized over two edges; push lands on the third.
                wait_clk(2);
                if (mode == 1) begin
                    if (q.size() > 0) check("same_cycle_head", rx_data, q[0]);
                    rx_ready = 1'b1;
                end else begin
                    clr_err = 1'b1;
                end
                wait_clk(1);
                rx_ready = 1'b0;
                clr_err  = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
        end
        if (mode == 1) void'(q.pop_front());
        if (mode == 2) begin
            exp_ovf   = 1'b0;
            exp_frame = 1'b0;
        end
        if (q.size() < CAP) q.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    task automatic drain();
        int t;
        while (q.size() > 0) begin
            t = 0;
            while (!rx_valid && t < 40) begin
                wait_clk(1);
                t++;
            end
            check("drain_valid", rx_valid, 1);
            check("drain_data", rx_data, q[0]);
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
            void'(q.pop_front());
        end
        wait_clk(1);
        check("empty_valid", rx_valid, 0);
        check("empty_level", rx_level, 0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err   = 1'b0;
        exp_ovf   = 1'b0;
        exp_frame = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        RST = 1'b1; MSI_SCLK = 1'b0; MSI_CS = 1'b1; MSI_SDATA = 1'b0;
        rx_ready = 1'b0; clr_err = 1'b0;
        wait_clk(3);
        check("rst_valid", rx_valid, 0);
        check("rst_level", rx_level, 0);
        check("rst_data", rx_data, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_frame", frame_err, 0);
        RST = 1'b0;
        wait_clk(2);

        // Pop from empty does nothing.
        rx_ready = 1'b1;
        wait_clk(2);
        rx_ready = 1'b0;
        check("empty_pop_level", rx_level, 0);
        check("empty_pop_valid", rx_valid, 0);

        // Single word.
        cs_begin();
        send_word(16'hA5C3, 0);
        check("w1_valid", rx_valid, 1);
        check("w1_data", rx_data, 16'hA5C3);
        cs_end();
        check("w1_no_frame_err", frame_err, exp_frame);
        drain();

        // Three back-to-back words in one frame, no pop.
        cs_begin();
        send_word(16'h0001, 0);
        send_word(16'h8000, 0);
        send_word(16'hFFFF, 0);
        cs_end();
        check("b2b_level", rx_level, q.size());
        check("b2b_ovf", ovf_err, exp_ovf);
        wait_clk(5);
        check("b2b_hold_data", rx_data, q[0]);
        drain();
        pulse_clr();
        check("b2b_ovf_clr", ovf_err, exp_ovf);

        // Partial word with one word already stored.
        cs_begin();
        send_word(16'h5A5A, 0);
        cs_end();
        cs_begin();
        for (int i = 0; i < 5; i++) begin
            MSI_SDATA = i[0];
            MSI_SCLK  = 1'b0;
            wait_clk(4);
            MSI_SCLK  = 1'b1;
            wait_clk(4);
        end
        cs_end();
        exp_frame = 1'b1;
        check("frame_err_set", frame_err, exp_frame);
        check("frame_level", rx_level, q.size());
        pulse_clr();
        check("frame_err_clr", frame_err, exp_frame);
        drain();

        // Fill to capacity, overflow with a coincident clr_err, then push+pop when full.
        cs_begin();
        for (int i = 0; i < CAP; i++) send_word(16'h1000 + 16'(i), 0);
        send_word(16'hDEAD, 2);
        check("ovf_set", ovf_err, exp_ovf);
        check("ovf_level", rx_level, q.size());
        pulse_clr();
        check("ovf_clr", ovf_err, exp_ovf);
        send_word(16'hBEEF, 1);
        cs_end();
        check("full_pushpop_ovf", ovf_err, exp_ovf);
        check("full_pushpop_level", rx_level, q.size());
        drain();

        // Reset mid-word, then a fresh frame.
        cs_begin();
        for (int i = 0; i < 9; i++) begin
            MSI_SDATA = 1'b1;
            MSI_SCLK  = 1'b0;
            wait_clk(4);
            MSI_SCLK  = 1'b1;
            wait_clk(4);
        end
        RST = 1'b1; MSI_CS = 1'b1; MSI_SCLK = 1'b0;
        wait_clk(2);
        RST = 1'b0;
        q.delete();
        exp_ovf = 1'b0; exp_frame = 1'b0;
        wait_clk(4);
        check("midrst_frame", frame_err, exp_frame);
        check("midrst_level", rx_level, 0);
        cs_begin();
        send_word(16'h1234, 0);
        cs_end();
        check("post_rst_data", rx_data, 16'h1234);
        check("post_rst_frame", frame_err, exp_frame);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
